// File: rtl/tournament_bp_param_pkg.sv
// Shared types and defaults for the tournament branch predictor.
package tournament_bp_param_pkg;

  // Defaults carried over from the existing predictor configuration.
  localparam int unsigned HISTORY_DEPTH      = 6;
  localparam int unsigned PERF_COUNTER_WIDTH = 32;

  typedef enum logic {
    BP_INIT  = 1'b0,
    BP_READY = 1'b1
  } bp_state_t;

  // Fixed-width part of a resolved-branch update; index/history fields are
  // parameter-sized and travel alongside it.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic        mispredict;
    logic        local_pr;
    logic        global_pr;
  } bp_update_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tournament_bp_param_sat_counter_table.sv
// Table of saturating counters: one combinational read port, one
// inc/dec update port and an initialisation write port (init wins).
module sat_counter_table #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0] o_rd_ctr,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_inc,
  input  logic             i_init_en,
  input  logic [IDX_W-1:0] i_init_idx,
  input  logic [CTR_W-1:0] i_init_val
);

  logic [CTR_W-1:0] r_mem [2**IDX_W];
  logic [CTR_W-1:0] w_cur;
  logic [CTR_W-1:0] w_next;

  assign o_rd_ctr = r_mem[i_rd_idx];

  // Next value of the updated entry, clamped at 0 and all-ones.
  always_comb begin
    w_cur  = r_mem[i_upd_idx];
    w_next = w_cur;
    if (i_upd_inc) begin
      if (w_cur != '1) w_next = w_cur + CTR_W'(1);
    end else begin
      if (w_cur != '0) w_next = w_cur - CTR_W'(1);
    end
  end

  // Table write: initialisation has priority over training updates.
  always_ff @(posedge clk) begin
    if (i_init_en) begin
      r_mem[i_init_idx] <= i_init_val;
    end else if (i_upd_en) begin
      r_mem[i_upd_idx] <= w_next;
    end
  end

endmodule

// File: rtl/tournament_bp_param.sv
// Tournament branch predictor: local-history and gshare components with a
// per-PC chooser, speculative GHR with repair, sequenced table init and
// prediction/mispredict counters.
module tournament_bp_param
  import tournament_bp_param_pkg::*;
#(
  parameter int unsigned HIST_W       = HISTORY_DEPTH,
  parameter int unsigned LHT_IDX_W    = 3,
  parameter int unsigned CHOICE_IDX_W = 3,
  parameter int unsigned CTR_W        = 2,
  parameter int unsigned PERF_W       = PERF_COUNTER_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic              pred_local,
  output logic              pred_global,
  output logic [HIST_W-1:0] pred_local_idx,
  output logic [HIST_W-1:0] pred_global_idx,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic [HIST_W-1:0] upd_local_idx,
  input  logic [HIST_W-1:0] upd_global_idx,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_local_pr,
  input  logic              upd_global_pr,
  output logic [PERF_W-1:0] perf_pred_cnt,
  output logic [PERF_W-1:0] perf_mispred_cnt
);

  localparam int unsigned INIT_W = max3(HIST_W, LHT_IDX_W, CHOICE_IDX_W);
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

  bp_state_t         r_state;
  logic [INIT_W-1:0] r_init_idx;
  logic [HIST_W-1:0] r_ghr;
  logic [PERF_W-1:0] r_perf_pred;
  logic [PERF_W-1:0] r_perf_mispred;
  logic [HIST_W-1:0] r_lht [2**LHT_IDX_W];

  bp_update_t        w_upd;
  logic              w_ready;
  logic              w_init_active;
  logic              w_init_pht;
  logic              w_init_lht;
  logic              w_init_choice;
  logic              w_upd_en;
  logic              w_choice_en;
  logic              w_repair;
  logic [LHT_IDX_W-1:0]    w_pred_lht_idx;
  logic [LHT_IDX_W-1:0]    w_upd_lht_idx;
  logic [CHOICE_IDX_W-1:0] w_pred_choice_idx;
  logic [CHOICE_IDX_W-1:0] w_upd_choice_idx;
  logic [HIST_W-1:0] w_local_idx;
  logic [HIST_W-1:0] w_global_idx;
  logic [CTR_W-1:0]  w_local_ctr;
  logic [CTR_W-1:0]  w_global_ctr;
  logic [CTR_W-1:0]  w_choice_ctr;
  logic              w_final;
  logic              w_unused;

  assign w_upd = '{valid:      upd_valid,
                   pc:         upd_pc,
                   taken:      upd_taken,
                   mispredict: upd_mispredict,
                   local_pr:   upd_local_pr,
                   global_pr:  upd_global_pr};

  assign w_ready       = (r_state == BP_READY);
  assign w_init_active = (r_state == BP_INIT);
  // Smaller tables ignore init indices beyond their depth.
  assign w_init_pht    = w_init_active && ((r_init_idx >> HIST_W) == '0);
  assign w_init_lht    = w_init_active && ((r_init_idx >> LHT_IDX_W) == '0);
  assign w_init_choice = w_init_active && ((r_init_idx >> CHOICE_IDX_W) == '0);

  assign w_upd_en    = w_ready && w_upd.valid;
  assign w_choice_en = w_upd_en && (w_upd.local_pr != w_upd.global_pr);
  assign w_repair    = w_upd_en && w_upd.mispredict;

  assign w_pred_lht_idx    = pred_pc[LHT_IDX_W+1:2];
  assign w_upd_lht_idx     = w_upd.pc[LHT_IDX_W+1:2];
  assign w_pred_choice_idx = pred_pc[CHOICE_IDX_W+1:2];
  assign w_upd_choice_idx  = w_upd.pc[CHOICE_IDX_W+1:2];

  assign w_local_idx  = r_lht[w_pred_lht_idx];
  assign w_global_idx = r_ghr ^ pred_pc[HIST_W+1:2];

  sat_counter_table #(.IDX_W(HIST_W), .CTR_W(CTR_W)) u_local_pht (
    .clk        (clk),
    .i_rd_idx   (w_local_idx),
    .o_rd_ctr   (w_local_ctr),
    .i_upd_en   (w_upd_en),
    .i_upd_idx  (upd_local_idx),
    .i_upd_inc  (w_upd.taken),
    .i_init_en  (w_init_pht),
    .i_init_idx (r_init_idx[HIST_W-1:0]),
    .i_init_val (CTR_WEAK_NT)
  );

  sat_counter_table #(.IDX_W(HIST_W), .CTR_W(CTR_W)) u_global_pht (
    .clk        (clk),
    .i_rd_idx   (w_global_idx),
    .o_rd_ctr   (w_global_ctr),
    .i_upd_en   (w_upd_en),
    .i_upd_idx  (upd_global_idx),
    .i_upd_inc  (w_upd.taken),
    .i_init_en  (w_init_pht),
    .i_init_idx (r_init_idx[HIST_W-1:0]),
    .i_init_val (CTR_WEAK_NT)
  );

  // Chooser counts toward global when global alone was right.
  sat_counter_table #(.IDX_W(CHOICE_IDX_W), .CTR_W(CTR_W)) u_choice (
    .clk        (clk),
    .i_rd_idx   (w_pred_choice_idx),
    .o_rd_ctr   (w_choice_ctr),
    .i_upd_en   (w_choice_en),
    .i_upd_idx  (w_upd_choice_idx),
    .i_upd_inc  (w_upd.global_pr == w_upd.taken),
    .i_init_en  (w_init_choice),
    .i_init_idx (r_init_idx[CHOICE_IDX_W-1:0]),
    .i_init_val (CTR_WEAK_NT)
  );

  assign w_final = w_choice_ctr[CTR_W-1] ? w_global_ctr[CTR_W-1]
                                         : w_local_ctr[CTR_W-1];

  assign ready            = w_ready;
  assign pred_taken       = w_ready & w_final;
  assign pred_local       = w_ready & w_local_ctr[CTR_W-1];
  assign pred_global      = w_ready & w_global_ctr[CTR_W-1];
  assign pred_local_idx   = w_local_idx;
  assign pred_global_idx  = w_global_idx;
  assign pred_ghr         = r_ghr;
  assign perf_pred_cnt    = r_perf_pred;
  assign perf_mispred_cnt = r_perf_mispred;

  assign w_unused = ^{pred_pc, upd_pc, upd_ghr};

  // Local history table: cleared during init, trained with resolved outcomes.
  always_ff @(posedge clk) begin
    if (w_init_lht) begin
      r_lht[r_init_idx[LHT_IDX_W-1:0]] <= '0;
    end else if (w_upd_en) begin
      r_lht[w_upd_lht_idx] <= {r_lht[w_upd_lht_idx][HIST_W-2:0], w_upd.taken};
    end
  end

  // Init sequencer, speculative/repaired GHR and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= BP_INIT;
      r_init_idx     <= '0;
      r_ghr          <= '0;
      r_perf_pred    <= '0;
      r_perf_mispred <= '0;
    end else begin
      case (r_state)
        BP_INIT: begin
          r_init_idx <= r_init_idx + INIT_W'(1);
          if (r_init_idx == '1) r_state <= BP_READY;
        end
        BP_READY: begin
          if (w_repair) begin
            r_ghr <= {upd_ghr[HIST_W-2:0], w_upd.taken};
          end else if (pred_valid) begin
            r_ghr <= {r_ghr[HIST_W-2:0], w_final};
          end
          if (pred_valid) r_perf_pred <= r_perf_pred + PERF_W'(1);
          if (w_repair) r_perf_mispred <= r_perf_mispred + PERF_W'(1);
        end
        default: r_state <= BP_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tournament_bp_param.sv
// Directed self-checking bench for tournament_bp_param (default parameters).
module tb_tournament_bp_param;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        pred_local;
  logic        pred_global;
  logic [5:0]  pred_local_idx;
  logic [5:0]  pred_global_idx;
  logic [5:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [5:0]  upd_local_idx;
  logic [5:0]  upd_global_idx;
  logic [5:0]  upd_ghr;
  logic        upd_local_pr;
  logic        upd_global_pr;
  logic [31:0] perf_pred_cnt;
  logic [31:0] perf_mispred_cnt;

  int n_assert;
  int n_fail;
  int cnt;

  tournament_bp_param #(
    .HIST_W       (6),
    .LHT_IDX_W    (3),
    .CHOICE_IDX_W (3),
    .CTR_W        (2),
    .PERF_W       (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ready            (ready),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .pred_local       (pred_local),
    .pred_global      (pred_global),
    .pred_local_idx   (pred_local_idx),
    .pred_global_idx  (pred_global_idx),
    .pred_ghr         (pred_ghr),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_mispredict   (upd_mispredict),
    .upd_local_idx    (upd_local_idx),
    .upd_global_idx   (upd_global_idx),
    .upd_ghr          (upd_ghr),
    .upd_local_pr     (upd_local_pr),
    .upd_global_pr    (upd_global_pr),
    .perf_pred_cnt    (perf_pred_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One resolved-branch update applied on the next rising edge.
  task automatic upd(input logic [31:0] pc, input logic [5:0] lidx,
                     input logic [5:0] gidx, input logic [5:0] ghr,
                     input logic taken, input logic mis,
                     input logic lpr, input logic gpr);
    upd_pc         = pc;
    upd_local_idx  = lidx;
    upd_global_idx = gidx;
    upd_ghr        = ghr;
    upd_taken      = taken;
    upd_mispredict = mis;
    upd_local_pr   = lpr;
    upd_global_pr  = gpr;
    upd_valid      = 1'b1;
    @(negedge clk);
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    pred_valid = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    upd_local_idx = '0; upd_global_idx = '0; upd_ghr = '0;
    upd_local_pr = 1'b0; upd_global_pr = 1'b0;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_taken", 32'(pred_taken), 32'd0);
    chk("rst_perf", perf_pred_cnt | perf_mispred_cnt, 32'd0);
    rst = 1'b1;
    wait_ready(cnt);
    chk("init_len", 32'(cnt), 32'd64);
    #1;
    pred_pc = 32'h1234_5678;
    #1;
    chk("rdy_taken", 32'(pred_taken), 32'd0);
    chk("rdy_local", 32'(pred_local), 32'd0);
    chk("rdy_global", 32'(pred_global), 32'd0);
    chk("rdy_ghr", 32'(pred_ghr), 32'd0);
    chk("rdy_pcnt", perf_pred_cnt, 32'd0);
    chk("rdy_mcnt", perf_mispred_cnt, 32'd0);
    chk("rdy_gidx", 32'(pred_global_idx), 32'h1E);

    // Local PHT[0]: 01 -> 10 -> 11 -> 11, observed via pc 0x108 (history 0)
    upd(32'h100, 6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    pred_pc = 32'h108;
    #1;
    chk("loc_inc1", 32'(pred_local), 32'd1);
    chk("loc_inc1_taken", 32'(pred_taken), 32'd1);
    upd(32'h100, 6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    upd(32'h100, 6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    pred_pc = 32'h108;
    #1;
    chk("loc_sat", 32'(pred_local), 32'd1);
    pred_pc = 32'h100;
    #1;
    chk("lht_hist", 32'(pred_local_idx), 32'h07);

    // Chooser at 0x104: 01 -> 10 flips selection from local to global
    pred_pc = 32'h104;
    #1;
    chk("choice_pre", 32'(pred_taken), 32'd1);
    upd(32'h104, 6'h3E, 6'h3E, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    pred_pc = 32'h104;
    #1;
    chk("choice_gidx", 32'(pred_global_idx), 32'h01);
    chk("choice_loc", 32'(pred_local), 32'd1);
    chk("choice_glb", 32'(pred_global), 32'd0);
    chk("choice_post", 32'(pred_taken), 32'd0);

    // Speculative GHR then mispredict repair
    pred_pc = 32'h108;
    pred_valid = 1'b1;
    #1;
    chk("spec_taken", 32'(pred_taken), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("spec_ghr", 32'(pred_ghr), 32'h07);
    chk("spec_pcnt", perf_pred_cnt, 32'd3);
    upd(32'h110, 6'h3D, 6'h3D, 6'b000101, 1'b1, 1'b1, 1'b0, 1'b0);
    pred_valid = 1'b0;
    chk("repair_ghr", 32'(pred_ghr), 32'h0B);
    chk("repair_mcnt", perf_mispred_cnt, 32'd1);
    chk("repair_pcnt", perf_pred_cnt, 32'd4);

    // Build history 5 at pc 0x10C, then same-cycle predict/update on PHT[5]
    upd(32'h10C, 6'h3C, 6'h3C, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    upd(32'h10C, 6'h3C, 6'h3C, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    upd(32'h10C, 6'h3C, 6'h3C, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    pred_pc = 32'h10C;
    #1;
    chk("same_lidx", 32'(pred_local_idx), 32'h05);
    upd_pc = 32'h118; upd_local_idx = 6'h05; upd_global_idx = 6'h3C;
    upd_ghr = '0; upd_taken = 1'b1; upd_mispredict = 1'b0;
    upd_local_pr = 1'b0; upd_global_pr = 1'b0;
    upd_valid = 1'b1;
    #1;
    chk("same_pre", 32'(pred_local), 32'd0);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    chk("same_post", 32'(pred_local), 32'd1);
    chk("same_post_taken", 32'(pred_taken), 32'd1);

    // Reset from READY, then again at INIT cycle 20
    rst = 1'b0;
    #1;
    chk("rst2_ready", 32'(ready), 32'd0);
    chk("rst2_ghr", 32'(pred_ghr), 32'd0);
    chk("rst2_perf", perf_pred_cnt | perf_mispred_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("mid_init_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // Requests during init must be ignored
    pred_valid = 1'b1;
    pred_pc = 32'h108;
    upd_pc = 32'h100; upd_local_idx = 6'h00; upd_global_idx = 6'h00;
    upd_ghr = 6'h15; upd_taken = 1'b1; upd_mispredict = 1'b1;
    upd_local_pr = 1'b1; upd_global_pr = 1'b0;
    upd_valid = 1'b1;
    rst = 1'b1;
    wait_ready(cnt);
    pred_valid = 1'b0;
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    chk("reinit_len", 32'(cnt), 32'd64);
    pred_pc = 32'h108;
    #1;
    chk("reinit_local", 32'(pred_local), 32'd0);
    chk("reinit_ghr", 32'(pred_ghr), 32'd0);
    chk("reinit_pcnt", perf_pred_cnt, 32'd0);
    chk("reinit_mcnt", perf_mispred_cnt, 32'd0);
    pred_pc = 32'h100;
    #1;
    chk("reinit_lht", 32'(pred_local_idx), 32'd0);
    pred_pc = 32'h104;
    #1;
    chk("reinit_choice", 32'(pred_taken), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tournament_bp_param.md
# tournament_bp_param

Parametrised tournament branch predictor for the pipelined RV32I core's fetch stage. It combines a per-PC local-history predictor and a gshare global predictor, with a per-PC choice table selecting between them. It replaces fixed-size predictor tables with configurable widths, adds speculative global-history update with mispredict repair, sequences table initialisation after reset, and counts predictions and mispredicts.

## Interface
- HIST_W, 6, local/global history bits; each PHT has 2^HIST_W entries.
- LHT_IDX_W, 3, local history table has 2^LHT_IDX_W entries.
- CHOICE_IDX_W, 3, choice table has 2^CHOICE_IDX_W entries.
- CTR_W, 2, saturating counter width, ≥2.
- PERF_W, 32, performance counter width.
- clk  in  1  clock.
- rst  in  1  reset; one clock domain; reset is asynchronous and active-low.
- ready  out  1  high once initialisation is done.
- pred_valid  in  1  fetch requests a prediction.
- pred_pc  in  32  fetch PC.
- pred_taken  out  1  final prediction.
- pred_local, pred_global  out  1 each  component predictions.
- pred_local_idx, pred_global_idx  out  HIST_W each  PHT indices used, carried down the pipe.
- pred_ghr  out  HIST_W  GHR before this prediction's shift.
- upd_valid  in  1  resolved conditional branch.
- upd_pc  in  32; upd_taken  in  1; upd_mispredict  in  1.
- upd_local_idx, upd_global_idx, upd_ghr  in  HIST_W each  values returned from prediction time.
- upd_local_pr, upd_global_pr  in  1 each.
- perf_pred_cnt, perf_mispred_cnt  out  PERF_W each.

## Operation
- LHT[pc[LHT_IDX_W+1:2]] holds HIST_W-bit histories. The local PHT is indexed by that history. The global PHT is indexed by ghr ^ pc[HIST_W+1:2]. The choice table is indexed by pc[CHOICE_IDX_W+1:2].
- A prediction is the counter MSB. A choice MSB of 1 selects global, 0 selects local.
- States are INIT and READY.
  - Reset forces INIT with the index counter, GHR, and perf counters at 0. ready, pred_taken, pred_local, and pred_global are 0.
  - INIT writes one index per cycle to all tables in parallel. Counters get the weak-not-taken value 2^(CTR_W-1)-1, and the choice table is weak-local at the same value. LHT entries are 0.
  - INIT lasts 2^max(HIST_W,LHT_IDX_W,CHOICE_IDX_W) cycles, then moves to READY. Out-of-range indices in the smaller tables are ignored.
  - pred_valid and upd_valid are ignored in INIT.
- Speculative GHR: when pred_valid is high in READY, ghr <= {ghr[HIST_W-2:0], pred_taken}.
- Repair: when upd_valid and upd_mispredict are both high, ghr <= {upd_ghr[HIST_W-2:0], upd_taken}. This overrides a same-cycle speculative shift.
- On upd_valid:
  - Local PHT[upd_local_idx] and global PHT[upd_global_idx] saturate toward upd_taken, clamped at 0 and 2^CTR_W-1.
  - LHT[upd_pc] shifts in upd_taken.
  - Choice entry: only when upd_local_pr != upd_global_pr. Increment if upd_global_pr == upd_taken, else decrement, saturating.
- Perf counters:
  - perf_pred_cnt increments on pred_valid in READY.
  - perf_mispred_cnt increments on upd_valid & upd_mispredict.
  - Both wrap modulo 2^PERF_W.

## Timing
- Prediction outputs are combinational from pred_pc and current state, with 0-cycle latency.
- Updates are visible from the cycle after the upd_valid edge.
- When a prediction and an update hit the same entry in the same cycle, the prediction sees the pre-update value.
- Reset mid-INIT or mid-READY restarts the full INIT sequence.
- ready rises on the first cycle after the last INIT write.

## Structure
- Shared package holds:
  - bp_state_t enum {BP_INIT, BP_READY}.
  - bp_update_t struct bundling the upd_* fields.
  - default localparams reused from existing history_depth and perf_counter_width.
- Sub-module sat_counter_table: parameters IDX_W and CTR_W. It has one combinational read port, one saturating inc/dec write port, and an init write port. It is instanced for the local PHT, the global PHT, and the choice table.

## Test plan
All scenarios use default parameters.

- Release rst after 3 cycles low: ready=0 for 64 cycles, then 1. Any pred_pc gives pred_taken=0, pred_ghr=0, perf counters 0.
- pc=0x100, three upd_valid taken with the same local idx: counter 01→10→11→11. Next pred_local=1 for that history.
- upd local_pr=1, global_pr=0, taken=0 at pc=0x104: choice 01→10. Next prediction for 0x104 follows pred_global.
- ghr=0; three pred_valid predicting taken give ghr=6'b000111. Then upd mispredict with upd_ghr=6'b000101, taken=1, simultaneous with pred_valid: ghr=6'b001011, perf_mispred_cnt=1.
- Assert rst at INIT cycle 20: ready stays 0 for a full 64 cycles after release.
- Same-cycle pred and upd to the same local idx at counter 01, taken: pred_local=0 this cycle, pred_local=1 next cycle.
